// File: rtl/aes_pkg.sv
// Shared constants and loader state encoding for the AES byte-stream front end.
package aes_pkg;

    localparam int unsigned AES_BLK_W     = 128;
    localparam int unsigned BYTES_PER_BLK = 16;
    localparam int unsigned CNT_W         = $clog2(BYTES_PER_BLK);

    localparam logic [7:0] CMD_KEY  = 8'h4B;
    localparam logic [7:0] CMD_DATA = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RX_KEY  = 2'd1,
        ST_RX_DATA = 2'd2,
        ST_PRESENT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/aes_shift_assembler.sv
// MSB-first byte shift register with byte count; shared by key and data frames.
module aes_shift_assembler
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load_en,
    input  logic [7:0]           byte_in,
    output logic [AES_BLK_W-1:0] shadow,
    output logic [CNT_W-1:0]     count
);

    // The count wraps 15->0 on the 16th load, which is exactly frame completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            count  <= '0;
        end else if (clr) begin
            shadow <= '0;
            count  <= '0;
        end else if (load_en) begin
            shadow <= {shadow[AES_BLK_W-9:0], byte_in};
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/aes_byte_loader.sv
// Assembles key and plaintext blocks from framed UART bytes and presents blocks
// to the cipher over a valid/ready handshake.
module aes_byte_loader
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100_000_000,
    parameter logic [7:0]  CMD_KEY     = aes_pkg::CMD_KEY,
    parameter logic [7:0]  CMD_DATA    = aes_pkg::CMD_DATA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [AES_BLK_W-1:0] key,
    output logic [AES_BLK_W-1:0] data_in,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic                 key_loaded,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic                 err_cmd,
    output logic                 err_nokey
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    loader_state_t        state, state_nxt;
    logic [TO_W-1:0]      tcnt, tcnt_nxt;
    logic [AES_BLK_W-1:0] sr_shadow;
    logic [CNT_W-1:0]     sr_count;
    logic                 sr_load, sr_clr;
    logic                 key_commit, data_commit;
    logic                 blk_valid_nxt, key_loaded_nxt;
    logic                 err_timeout_nxt, err_overrun_nxt, err_cmd_nxt, err_nokey_nxt;
    logic [AES_BLK_W-1:0] assembled;

    aes_shift_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sr_clr),
        .load_en (sr_load),
        .byte_in (rx_data),
        .shadow  (sr_shadow),
        .count   (sr_count)
    );

    // Block as it will look once the byte on rx_data has been shifted in.
    assign assembled = {sr_shadow[AES_BLK_W-9:0], rx_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        tcnt_nxt        = '0;
        sr_load         = 1'b0;
        sr_clr          = 1'b0;
        key_commit      = 1'b0;
        data_commit     = 1'b0;
        blk_valid_nxt   = blk_valid;
        key_loaded_nxt  = key_loaded;
        err_timeout_nxt = 1'b0;
        err_overrun_nxt = 1'b0;
        err_cmd_nxt     = 1'b0;
        err_nokey_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_KEY)       state_nxt = ST_RX_KEY;
                    else if (rx_data == CMD_DATA) state_nxt = ST_RX_DATA;
                    else                          err_cmd_nxt = 1'b1;
                end
            end
            ST_RX_KEY, ST_RX_DATA: begin
                if (rx_valid) begin
                    sr_load = 1'b1;
                    if (sr_count == CNT_W'(BYTES_PER_BLK - 1)) begin
                        state_nxt = ST_IDLE;
                        if (state == ST_RX_KEY) begin
                            key_commit     = 1'b1;
                            key_loaded_nxt = 1'b1;
                        end else if (key_loaded) begin
                            data_commit   = 1'b1;
                            blk_valid_nxt = 1'b1;
                            state_nxt     = ST_PRESENT;
                        end else begin
                            err_nokey_nxt = 1'b1;
                        end
                    end
                end else if (tcnt == TO_LAST) begin
                    err_timeout_nxt = 1'b1;
                    sr_clr          = 1'b1;
                    state_nxt       = ST_IDLE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            ST_PRESENT: begin
                err_overrun_nxt = rx_valid;
                if (blk_ready) begin
                    blk_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key         <= '0;
            data_in     <= '0;
            blk_valid   <= 1'b0;
            key_loaded  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_cmd     <= 1'b0;
            err_nokey   <= 1'b0;
        end else begin
            if (key_commit)  key     <= assembled;
            if (data_commit) data_in <= assembled;
            blk_valid   <= blk_valid_nxt;
            key_loaded  <= key_loaded_nxt;
            err_timeout <= err_timeout_nxt;
            err_overrun <= err_overrun_nxt;
            err_cmd     <= err_cmd_nxt;
            err_nokey   <= err_nokey_nxt;
        end
    end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed bench for aes_byte_loader: key/data framing, handshake, error pulses, reset.
module tb_aes_byte_loader;

    localparam int unsigned TO = 50;
    localparam logic [127:0] KEY1 = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] BLK1 = 128'h54776F204F6E65204E696E652054776F;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         blk_ready = 1'b0;
    logic [127:0] key, data_in;
    logic         blk_valid, key_loaded;
    logic         err_timeout, err_overrun, err_cmd, err_nokey;

    int n_cmp = 0;
    int n_err = 0;

    aes_byte_loader #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .key         (key),
        .data_in     (data_in),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .key_loaded  (key_loaded),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .err_cmd     (err_cmd),
        .err_nokey   (err_nokey)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Drives cmd + 16 bytes back to back; returns with the last byte still on the bus.
    task automatic frame_body(input logic [7:0] cmd, input logic [127:0] blk);
        send_byte(cmd);
        for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8]);
    endtask

    function automatic logic [3:0] errs();
        return {err_timeout, err_overrun, err_cmd, err_nokey};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit;
        repeat (3) @(negedge clk);
        chk("rst_key", key, '0);
        chk("rst_data", data_in, '0);
        chk("rst_ctl", {blk_valid, key_loaded, errs()}, '0);
        rst_n = 1'b1;

        // Unknown command in IDLE
        send_byte(8'h00);
        idle_rx();
        chk("cmd_err_pulse", err_cmd, 1'b1);
        @(negedge clk);
        chk("cmd_err_clear", err_cmd, 1'b0);

        // Data frame without a key
        frame_body(8'h44, BLK1);
        idle_rx();
        chk("nokey_pulse", err_nokey, 1'b1);
        chk("nokey_blkvalid", blk_valid, 1'b0);
        chk("nokey_data", data_in, '0);
        send_byte(8'h00);
        idle_rx();
        chk("nokey_idle", {err_cmd, err_nokey}, 2'b10);

        // Key frame, including the one-cycle commit latency
        frame_body(8'h4B, KEY1);
        chk("key_pre_commit", {key_loaded, key}, {1'b0, 128'h0});
        idle_rx();
        chk("key_commit", key, KEY1);
        chk("key_loaded", key_loaded, 1'b1);

        // Data frame held by backpressure
        frame_body(8'h44, BLK1);
        idle_rx();
        chk("blk_valid_set", blk_valid, 1'b1);
        chk("blk_data", data_in, BLK1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("blk_hold", {blk_valid, data_in, key == KEY1}, {1'b1, BLK1, 1'b1});
        end
        send_byte(8'hAA);
        idle_rx();
        chk("overrun_pulse", err_overrun, 1'b1);
        chk("overrun_hold", {blk_valid, data_in}, {1'b1, BLK1});
        @(negedge clk);
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        chk("xfer_drop", blk_valid, 1'b0);
        chk("xfer_errclr", err_overrun, 1'b0);

        // blk_ready with nothing presented is ignored
        blk_ready = 1'b1;
        repeat (2) @(negedge clk);
        blk_ready = 1'b0;
        chk("ready_idle", blk_valid, 1'b0);

        // Byte arriving in the transfer cycle is dropped
        frame_body(8'h44, KEY1);
        idle_rx();
        chk("blk2_data", {blk_valid, data_in}, {1'b1, KEY1});
        @(negedge clk);
        blk_ready = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h4B;
        @(negedge clk);
        blk_ready = 1'b0;
        rx_valid  = 1'b0;
        chk("same_cyc", {blk_valid, err_overrun}, 2'b01);
        send_byte(8'h00);
        idle_rx();
        chk("same_cyc_idle", err_cmd, 1'b1);

        // Inter-byte timeout on a partial key frame
        send_byte(8'h4B);
        for (int i = 0; i < 5; i++) send_byte(8'h11 * (i + 1));
        idle_rx();
        hit = -1;
        for (int i = 1; i <= 3 * TO && hit < 0; i++) begin
            @(negedge clk);
            if (err_timeout) hit = i;
        end
        chk("timeout_seen", hit >= 0, 1'b1);
        chk("timeout_window", (hit >= int'(TO) - 3) && (hit <= int'(TO) + 3), 1'b1);
        chk("timeout_key", {key_loaded, key}, {1'b1, KEY1});
        @(negedge clk);
        chk("timeout_clear", err_timeout, 1'b0);
        frame_body(8'h4B, BLK1);
        idle_rx();
        chk("key_after_to", key, BLK1);

        // Asynchronous reset in the middle of a data frame
        send_byte(8'h44);
        for (int i = 0; i < 3; i++) send_byte(8'h5A);
        idle_rx();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", {key, data_in}, '0);
        chk("async_rst_ctl", {blk_valid, key_loaded, errs()}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_body(8'h44, BLK1);
        idle_rx();
        chk("post_rst_nokey", {err_nokey, blk_valid}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
